mac_seq_r4_param: RTL and testbench
===================================

Name: mac_seq_r4_param

Overview:
- Parametrised iterative radix-4 Booth multiply-accumulate unit; successor to the fixed 256-bit MAC.
- Adds selectable signed/unsigned operands, configurable accumulator width, a valid/ready input handshake, a per-operation accumulator clear, a global stall enable and a sticky overflow flag.
- Sits between an operand-stream source and a result consumer in the MAC datapath. One multiply is in flight at a time.

Parameters:
- WIDTH, 256, operand width in bits. Must be even and >= 4.
- ACC_WIDTH, 512, accumulator width in bits. Must be >= 2*WIDTH.
- SIGNED, 0, operand encoding: 0 = unsigned, 1 = two's complement.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  global enable. When 0, all state freezes.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  unit can accept an operand pair.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_clr  in  1  sampled with the operand pair. 1 means acc = product, not acc + product.
- out_valid  out  1  one-cycle pulse: acc_out has just been updated.
- acc_out  out  ACC_WIDTH  accumulator value.
- overflow  out  1  sticky accumulate overflow.
- busy  out  1  high in MULT and ACC states.

Behaviour:
- Reset values: state IDLE; acc_out 0; overflow 0; out_valid 0; busy 0; in_ready 1. Internal operand, partial-product and counter registers are 0.
- Reset asserted mid-operation aborts the operation. The in-flight product is discarded and no out_valid is produced.
- Iteration count: ITER = WIDTH/2 + 1 when SIGNED=0 (the extra digit covers the zero-extended MSB); ITER = WIDTH/2 when SIGNED=1.
- FSM states:
  - IDLE: in_ready=1. Accept on the edge where in_valid && in_ready && en. Latch in_a, in_b, in_clr; set counter=0, partial=0; go to MULT. Inputs are sampled only on this edge.
  - MULT: in_ready=0. Each enabled edge does one Booth step: examine 3 bits of the shifted multiplier, add 0/±A/±2A shifted by 2*counter into the partial product, increment counter. When counter reaches ITER-1, go to ACC on the following edge.
  - ACC: one edge does the accumulate. acc_out <= (clr ? 0 : acc_out) + product, with the product sign- or zero-extended to ACC_WIDTH and wrapped mod 2^ACC_WIDTH. Set out_valid for the next cycle; return to IDLE.
- Latency: acceptance edge at k gives out_valid high in the cycle after edge k+ITER+1.
- Back-to-back operations: in_ready rises in the same cycle out_valid is high. Maximum throughput is one op per ITER+2 cycles.
- Overflow:
  - Unsigned: set on carry-out of the accumulate.
  - Signed: set when both operands of the add have the same sign and the result sign differs.
  - When an op with clr=1 is accepted, overflow is cleared; it is then updated only by that op's own result.
  - Holds until the next clr op or reset.
- en=0: no state, counter, accumulator or flag changes, and no handshake. out_valid is held low while en=0; a pending out_valid pulse is emitted on the first enabled cycle.
- in_valid while busy is ignored because in_ready=0. The source must hold in_valid and the operand data until accepted.

Decomposition:
- Shared package mac_pkg holds:
  - the FSM state encoding (IDLE, MULT, ACC);
  - the function computing ITER from WIDTH and SIGNED;
  - the Booth-digit decode constants (0, +1, +2, -1, -2).
- Sub-module booth_r4_step: combinational. Takes a 3-bit multiplier window and the extended multiplicand; produces the selected partial product and its negate flag. The top level owns the FSM, counter, shift registers and accumulator adder.

Test Plan:
- WIDTH=8, ACC=16, SIGNED=0: accept 255*255 with clr=1 -> acc_out=65025 (0xFE01), out_valid pulse exactly 6 cycles after acceptance, overflow=0.
- Same config, then 255*255 with clr=0 -> acc_out=64514 (0xFC02), overflow=1. Then 3*4 with clr=1 -> acc_out=12, overflow=0.
- WIDTH=8, ACC=16, SIGNED=1: -3*5 with clr=1 -> acc_out=0xFFF1; then -128*-128 with clr=0 -> 0x3FF1, overflow=0.
- Drop en for 3 cycles mid-MULT -> acc_out and counter frozen; out_valid delayed by exactly 3 cycles; result unchanged.
- Assert rst_n low mid-MULT, then accept 7*9 with clr=0 -> no out_valid from the aborted op; acc_out=63.
- Hold in_valid continuously with new operands -> in_ready low while busy; each accepted pair is accumulated exactly once; throughput is one op per ITER+2 cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth MAC.
package mac_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle,
    StMult,
    StAcc
  } mac_state_e;

  // Radix-4 Booth digit values selected by one 3-bit multiplier window.
  typedef enum logic [2:0] {
    DigZero,
    DigPos1,
    DigPos2,
    DigNeg1,
    DigNeg2
  } booth_digit_e;

  // Number of Booth steps. Unsigned operands need one extra digit so the
  // zero-extended MSB is never read as a sign bit.
  function automatic int unsigned calc_iter(input int unsigned width,
                                            input int unsigned signed_mode);
    return (signed_mode != 0) ? (width / 2) : (width / 2 + 1);
  endfunction

  // Window {b[2i+1], b[2i], b[2i-1]} to digit.
  function automatic booth_digit_e booth_decode(input logic [2:0] win);
    booth_digit_e dig;
    case (win)
      3'b000, 3'b111: dig = DigZero;
      3'b001, 3'b010: dig = DigPos1;
      3'b011:         dig = DigPos2;
      3'b100:         dig = DigNeg2;
      default:        dig = DigNeg1;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_step.sv
// Combinational radix-4 Booth selector: picks 0, A or 2A and flags negation.
module booth_r4_step
  import mac_pkg::*;
#(
  parameter int unsigned PW = 16
) (
  input  logic [2:0]    i_win,
  input  logic [PW-1:0] i_mcand,
  output logic [PW-1:0] o_pp,
  output logic          o_neg
);

  booth_digit_e w_dig;

  assign w_dig = booth_decode(i_win);

  // Magnitude select; the caller applies the two's-complement negate.
  always_comb begin
    o_pp  = '0;
    o_neg = 1'b0;
    unique case (w_dig)
      DigZero: o_pp = '0;
      DigPos1: o_pp = i_mcand;
      DigPos2: o_pp = {i_mcand[PW-2:0], 1'b0};
      DigNeg1: begin
        o_pp  = i_mcand;
        o_neg = 1'b1;
      end
      DigNeg2: begin
        o_pp  = {i_mcand[PW-2:0], 1'b0};
        o_neg = 1'b1;
      end
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/mac_seq_r4_param.sv
// Iterative radix-4 Booth multiply-accumulate with valid/ready input,
// per-op accumulator clear, global stall and sticky overflow.
module mac_seq_r4_param
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH     = 256,
  parameter int unsigned ACC_WIDTH = 512,
  parameter int unsigned SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_clr,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 overflow,
  output logic                 busy
);

  localparam int unsigned ITER = calc_iter(WIDTH, SIGNED);
  localparam int unsigned PW   = 2 * WIDTH;   // product width
  localparam int unsigned MB   = 2 * ITER;    // extended multiplier width
  localparam int unsigned CW   = $clog2(ITER + 1);

  mac_state_e           r_state;
  logic [PW-1:0]        r_a;      // multiplicand, pre-shifted by 2 per step
  logic [MB:0]          r_b;      // {multiplier, 1'b0}, shifted right by 2 per step
  logic [PW-1:0]        r_part;
  logic [CW-1:0]        r_cnt;
  logic                 r_clr;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;
  logic                 r_pend;   // result pulse waiting for an enabled cycle

  logic [PW-1:0]        w_a_ext;
  logic [MB-1:0]        w_b_ext;
  logic [PW-1:0]        w_sel;
  logic                 w_neg;
  logic [PW-1:0]        w_pp;
  logic [ACC_WIDTH-1:0] w_prod_ext;
  logic [ACC_WIDTH-1:0] w_base;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_ovf;

  assign w_a_ext = (SIGNED != 0) ? PW'($signed(in_a)) : PW'(in_a);
  assign w_b_ext = (SIGNED != 0) ? MB'($signed(in_b)) : MB'(in_b);

  booth_r4_step #(
    .PW (PW)
  ) u_step (
    .i_win   (r_b[2:0]),
    .i_mcand (r_a),
    .o_pp    (w_sel),
    .o_neg   (w_neg)
  );

  // Booth term and accumulate datapath.
  always_comb begin
    w_pp       = w_neg ? ((~w_sel) + PW'(1)) : w_sel;
    w_prod_ext = (SIGNED != 0) ? ACC_WIDTH'($signed(r_part)) : ACC_WIDTH'(r_part);
    w_base     = r_clr ? '0 : r_acc;
    w_sum      = {1'b0, w_base} + {1'b0, w_prod_ext};
    if (SIGNED != 0) begin
      w_ovf = (w_base[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
              (w_sum[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]);
    end else begin
      w_ovf = w_sum[ACC_WIDTH];
    end
  end

  // Controller, multiplier iteration and accumulator; everything holds while en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_cnt   <= '0;
      r_clr   <= 1'b0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_pend  <= 1'b0;
    end else if (en) begin
      r_pend <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a     <= w_a_ext;
            r_b     <= {w_b_ext, 1'b0};
            r_clr   <= in_clr;
            r_cnt   <= '0;
            r_part  <= '0;
            r_state <= StMult;
            if (in_clr) r_ovf <= 1'b0;
          end
        end
        StMult: begin
          r_part <= r_part + w_pp;
          r_a    <= {r_a[PW-3:0], 2'b00};
          r_b    <= {2'b00, r_b[MB:2]};
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(ITER - 1)) r_state <= StAcc;
        end
        StAcc: begin
          r_acc   <= w_sum[ACC_WIDTH-1:0];
          r_ovf   <= r_ovf | w_ovf;
          r_pend  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign out_valid = r_pend & en;
  assign acc_out   = r_acc;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_mac_seq_r4_param.sv
// Directed bench for mac_seq_r4_param: an unsigned and a signed 8x8->16 instance.
module tb_mac_seq_r4_param;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk = ~clk;

  logic        u_in_valid, u_in_ready, u_in_clr, u_out_valid, u_overflow, u_busy;
  logic [7:0]  u_in_a, u_in_b;
  logic [15:0] u_acc_out;

  logic        s_in_valid, s_in_ready, s_in_clr, s_out_valid, s_overflow, s_busy;
  logic [7:0]  s_in_a, s_in_b;
  logic [15:0] s_acc_out;

  int n_checks = 0;
  int n_fail   = 0;

  mac_seq_r4_param #(
    .WIDTH     (8),
    .ACC_WIDTH (16),
    .SIGNED    (0)
  ) u_dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (u_in_valid),
    .in_ready  (u_in_ready),
    .in_a      (u_in_a),
    .in_b      (u_in_b),
    .in_clr    (u_in_clr),
    .out_valid (u_out_valid),
    .acc_out   (u_acc_out),
    .overflow  (u_overflow),
    .busy      (u_busy)
  );

  mac_seq_r4_param #(
    .WIDTH     (8),
    .ACC_WIDTH (16),
    .SIGNED    (1)
  ) u_dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_a      (s_in_a),
    .in_b      (s_in_b),
    .in_clr    (s_in_clr),
    .out_valid (s_out_valid),
    .acc_out   (s_acc_out),
    .overflow  (s_overflow),
    .busy      (s_busy)
  );

  // One op on the unsigned unit; lat = cycles from acceptance edge to pulse, -1 on timeout.
  // en is dropped for stall_len cycles starting stall_at cycles after acceptance.
  task automatic run_u(input logic [7:0] a, input logic [7:0] b, input logic clr,
                       input int stall_at, input int stall_len, output int lat);
    bit took = 1'b0;
    u_in_a = a; u_in_b = b; u_in_clr = clr; u_in_valid = 1'b1;
    for (int i = 0; i < 20 && !took; i++) begin
      took = u_in_ready && en;
      @(posedge clk); #1;
    end
    u_in_valid = 1'b0;
    lat = -1;
    if (took) begin
      for (int c = 1; c <= 40 && lat < 0; c++) begin
        if (c == stall_at) en = 1'b0;
        if (c == stall_at + stall_len) en = 1'b1;
        @(posedge clk); #1;
        if (u_out_valid) lat = c;
      end
    end
    en = 1'b1;
  endtask

  task automatic run_s(input logic [7:0] a, input logic [7:0] b, input logic clr,
                       output int lat);
    bit took = 1'b0;
    s_in_a = a; s_in_b = b; s_in_clr = clr; s_in_valid = 1'b1;
    for (int i = 0; i < 20 && !took; i++) begin
      took = s_in_ready && en;
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    lat = -1;
    if (took) begin
      for (int c = 1; c <= 40 && lat < 0; c++) begin
        @(posedge clk); #1;
        if (s_out_valid) lat = c;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    u_in_valid = 1'b0; u_in_a = '0; u_in_b = '0; u_in_clr = 1'b0;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (u_acc_out !== 16'h0) begin
      n_fail++; $display("FAIL reset_u_acc: got %h want 0000", u_acc_out);
    end
    n_checks++;
    if ({u_overflow, u_out_valid, u_busy, u_in_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_u_flags: got %b want 0001",
                         {u_overflow, u_out_valid, u_busy, u_in_ready});
    end
    n_checks++;
    if (s_acc_out !== 16'h0) begin
      n_fail++; $display("FAIL reset_s_acc: got %h want 0000", s_acc_out);
    end
    n_checks++;
    if ({s_overflow, s_out_valid, s_busy, s_in_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_s_flags: got %b want 0001",
                         {s_overflow, s_out_valid, s_busy, s_in_ready});
    end
  endtask

  task automatic test_unsigned();
    int lat;
    run_u(8'd255, 8'd255, 1'b1, 0, 0, lat);
    n_checks++;
    if (lat !== 6) begin n_fail++; $display("FAIL u_latency: got %0d want 6", lat); end
    n_checks++;
    if (u_acc_out !== 16'hFE01) begin
      n_fail++; $display("FAIL u_255x255: got %h want fe01", u_acc_out);
    end
    n_checks++;
    if (u_overflow !== 1'b0) begin n_fail++; $display("FAIL u_ovf0: got %b want 0", u_overflow); end
    n_checks++;
    if (u_in_ready !== 1'b1 || u_busy !== 1'b0) begin
      n_fail++; $display("FAIL u_ready_with_pulse: got ready=%b busy=%b want 1 0",
                         u_in_ready, u_busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (u_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL u_pulse_width: got %b want 0", u_out_valid);
    end
    run_u(8'd255, 8'd255, 1'b0, 0, 0, lat);
    n_checks++;
    if (u_acc_out !== 16'hFC02) begin
      n_fail++; $display("FAIL u_accum_wrap: got %h want fc02", u_acc_out);
    end
    n_checks++;
    if (u_overflow !== 1'b1) begin n_fail++; $display("FAIL u_ovf1: got %b want 1", u_overflow); end
    run_u(8'd3, 8'd4, 1'b1, 0, 0, lat);
    n_checks++;
    if (u_acc_out !== 16'd12) begin
      n_fail++; $display("FAIL u_clr_3x4: got %h want 000c", u_acc_out);
    end
    n_checks++;
    if (u_overflow !== 1'b0) begin
      n_fail++; $display("FAIL u_ovf_cleared: got %b want 0", u_overflow);
    end
  endtask

  task automatic test_signed();
    int lat;
    run_s(8'hFD, 8'h05, 1'b1, lat);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL s_latency: got %0d want 5", lat); end
    n_checks++;
    if (s_acc_out !== 16'hFFF1) begin
      n_fail++; $display("FAIL s_m3x5: got %h want fff1", s_acc_out);
    end
    run_s(8'h80, 8'h80, 1'b0, lat);
    n_checks++;
    if (s_acc_out !== 16'h3FF1) begin
      n_fail++; $display("FAIL s_m128sq: got %h want 3ff1", s_acc_out);
    end
    n_checks++;
    if (s_overflow !== 1'b0) begin n_fail++; $display("FAIL s_ovf0: got %b want 0", s_overflow); end
    run_s(8'h80, 8'h80, 1'b0, lat);
    n_checks++;
    if (s_acc_out !== 16'h7FF1 || s_overflow !== 1'b0) begin
      n_fail++; $display("FAIL s_to_max: got %h ovf=%b want 7ff1 ovf=0", s_acc_out, s_overflow);
    end
    run_s(8'h80, 8'h80, 1'b0, lat);
    n_checks++;
    if (s_acc_out !== 16'hBFF1 || s_overflow !== 1'b1) begin
      n_fail++; $display("FAIL s_pos_ovf: got %h ovf=%b want bff1 ovf=1", s_acc_out, s_overflow);
    end
  endtask

  task automatic test_stall();
    int lat;
    run_u(8'd5, 8'd6, 1'b1, 2, 3, lat);
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL stall_latency: got %0d want 9", lat); end
    n_checks++;
    if (u_acc_out !== 16'd30) begin
      n_fail++; $display("FAIL stall_result: got %h want 001e", u_acc_out);
    end
  endtask

  task automatic test_reset_abort();
    int  lat;
    bit  seen = 1'b0;
    u_in_a = 8'd9; u_in_b = 8'd9; u_in_clr = 1'b1; u_in_valid = 1'b1;
    @(posedge clk); #1;
    u_in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (u_busy !== 1'b0 || u_acc_out !== 16'h0) begin
      n_fail++; $display("FAIL abort_async: got busy=%b acc=%h want 0 0000", u_busy, u_acc_out);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (u_out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_pulse: got pulse want none"); end
    run_u(8'd7, 8'd9, 1'b0, 0, 0, lat);
    n_checks++;
    if (u_acc_out !== 16'd63 || lat !== 6) begin
      n_fail++; $display("FAIL abort_next_op: got acc=%h lat=%0d want 003f 6", u_acc_out, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va [4] = '{8'd2, 8'd4, 8'd6, 8'd10};
    logic [7:0]  vb [4] = '{8'd3, 8'd5, 8'd7, 8'd11};
    logic [15:0] exp_acc [4] = '{16'd6, 16'd26, 16'd68, 16'd178};
    int idx = 0, npulse = 0, cyc = 0, last = 0;
    bit take;
    u_in_a = va[0]; u_in_b = vb[0]; u_in_clr = 1'b1; u_in_valid = 1'b1;
    while (npulse < 4 && cyc < 200) begin
      take = u_in_valid && u_in_ready;
      if (u_busy) begin
        n_checks++;
        if (u_in_ready !== 1'b0) begin
          n_fail++; $display("FAIL b2b_ready_busy: got %b want 0 at cycle %0d", u_in_ready, cyc);
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (u_out_valid) begin
        n_checks++;
        if (u_acc_out !== exp_acc[npulse]) begin
          n_fail++; $display("FAIL b2b_acc%0d: got %h want %h", npulse, u_acc_out,
                             exp_acc[npulse]);
        end
        npulse++;
      end
      if (take) begin
        if (idx > 0) begin
          n_checks++;
          if (cyc - last !== 7) begin
            n_fail++; $display("FAIL b2b_interval: got %0d want 7", cyc - last);
          end
        end
        last = cyc;
        idx++;
        if (idx < 4) begin
          u_in_a = va[idx]; u_in_b = vb[idx]; u_in_clr = 1'b0;
        end else begin
          u_in_valid = 1'b0;
        end
      end
    end
    u_in_valid = 1'b0;
    n_checks++;
    if (npulse !== 4 || idx !== 4) begin
      n_fail++; $display("FAIL b2b_count: got pulses=%0d accepts=%0d want 4 4", npulse, idx);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
